// File: rtl/hack_alu_datapath_pkg.sv
// Shared definitions for the Hack ALU datapath: width, ctl/jmp bit positions
// and the named ALU control codes used by the Hack instruction set.
package hack_alu_datapath_pkg;

    localparam int WIDTH = 16;

    // ctl = {zx,nx,zy,ny,f,no}
    localparam int CTL_ZX = 5;
    localparam int CTL_NX = 4;
    localparam int CTL_ZY = 3;
    localparam int CTL_NY = 2;
    localparam int CTL_F  = 1;
    localparam int CTL_NO = 0;

    // jmp = {jlt,jeq,jgt}
    localparam int JMP_LT = 2;
    localparam int JMP_EQ = 1;
    localparam int JMP_GT = 0;

    localparam logic [5:0] CTL_ZERO  = 6'b101010;
    localparam logic [5:0] CTL_ONE   = 6'b111111;
    localparam logic [5:0] CTL_NEG1  = 6'b111010;
    localparam logic [5:0] CTL_X     = 6'b001100;
    localparam logic [5:0] CTL_NOTX  = 6'b001101;
    localparam logic [5:0] CTL_XPY   = 6'b000010;
    localparam logic [5:0] CTL_XMY   = 6'b010011;
    localparam logic [5:0] CTL_YMX   = 6'b000111;
    localparam logic [5:0] CTL_XANDY = 6'b000000;
    localparam logic [5:0] CTL_XORY  = 6'b010101;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zr;
        logic             ng;
    } aluResult_t;

endpackage

// File: rtl/hack_alu_datapath_core.sv
// Combinational Hack ALU: operand zero/negate, add-or-and, optional output
// negate, plus the zr/ng result flags.
module hack_alu_core
    import hack_alu_datapath_pkg::*;
(
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [5:0]       ctl,
    output logic [WIDTH-1:0] result,
    output logic             zr,
    output logic             ng
);

    logic [WIDTH-1:0] x1, x2, y1, y2, r;

    always_comb begin
        x1 = ctl[CTL_ZX] ? '0 : x;
        x2 = ctl[CTL_NX] ? ~x1 : x1;
        y1 = ctl[CTL_ZY] ? '0 : y;
        y2 = ctl[CTL_NY] ? ~y1 : y1;
        // Carry out is dropped: overflow wraps with no flag.
        r  = ctl[CTL_F] ? (x2 + y2) : (x2 & y2);
    end

    assign result = ctl[CTL_NO] ? ~r : r;
    assign zr     = (result == '0);
    assign ng     = result[WIDTH-1];

endmodule

// File: rtl/hack_alu_datapath.sv
// Hack ALU datapath: Y-source mux, ALU core, jump decision and a single
// output register stage (1-cycle latency, no backpressure).
module hack_alu_datapath
    import hack_alu_datapath_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] a_val,
    input  logic [WIDTH-1:0] m_val,
    input  logic             a_sel,
    input  logic [5:0]       ctl,
    input  logic [2:0]       jmp,
    input  logic             c_inst,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng,
    output logic             jump
);

    logic [WIDTH-1:0] y;
    aluResult_t       alu;
    logic             jumpNext;

    assign y = a_sel ? m_val : a_val;

    hack_alu_core uCore (
        .x      (x),
        .y      (y),
        .ctl    (ctl),
        .result (alu.result),
        .zr     (alu.zr),
        .ng     (alu.ng)
    );

    // Jump uses this cycle's flags, so it lands in the same register stage as out.
    assign jumpNext = c_inst & ((jmp[JMP_LT] & alu.ng)
                              | (jmp[JMP_EQ] & alu.zr)
                              | (jmp[JMP_GT] & ~alu.zr & ~alu.ng));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out       <= '0;
            zr        <= 1'b0;
            ng        <= 1'b0;
            jump      <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out  <= alu.result;
                zr   <= alu.zr;
                ng   <= alu.ng;
                jump <= jumpNext;
            end
        end
    end

endmodule

// File: tb/tb_hack_alu_datapath.sv
// Self-checking bench for hack_alu_datapath: directed cases from the
// requirement examples, reset behaviour, then randomized ops vs a reference.
module tb_hack_alu_datapath;
    import hack_alu_datapath_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] x, a_val, m_val;
    logic        a_sel;
    logic [5:0]  ctl;
    logic [2:0]  jmp;
    logic        c_inst;
    logic        out_valid;
    logic [15:0] out;
    logic        zr, ng, jump;

    int nCmp = 0;
    int nBad = 0;

    // reference state of the output register
    logic [15:0] mOut;
    logic        mValid, mZr, mNg, mJump;

    hack_alu_datapath dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .x(x), .a_val(a_val),
        .m_val(m_val), .a_sel(a_sel), .ctl(ctl), .jmp(jmp), .c_inst(c_inst),
        .out_valid(out_valid), .out(out), .zr(zr), .ng(ng), .jump(jump)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCmp++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Integer-arithmetic model: negation of a 16-bit value is 65535 - v.
    function automatic int aluRef(input int xv, input int yv, input logic [5:0] c);
        int x1, y1, r;
        x1 = c[5] ? 0 : xv;
        if (c[4]) x1 = 65535 - x1;
        y1 = c[3] ? 0 : yv;
        if (c[2]) y1 = 65535 - y1;
        r = c[1] ? (x1 + y1) % 65536 : (x1 & y1);
        if (c[0]) r = 65535 - r;
        return r;
    endfunction

    function automatic logic jumpRef(input int res, input logic [2:0] j, input logic ci);
        int s;
        s = (res >= 32768) ? res - 65536 : res;
        return ci && ((j[2] && s < 0) || (j[1] && s == 0) || (j[0] && s > 0));
    endfunction

    task automatic drive(input logic v, input logic [15:0] xv, input logic [15:0] av,
                         input logic [15:0] mv, input logic sel, input logic [5:0] c,
                         input logic [2:0] j, input logic ci);
        in_valid = v; x = xv; a_val = av; m_val = mv; a_sel = sel;
        ctl = c; jmp = j; c_inst = ci;
    endtask

    // Update the model from the driven inputs, clock once, compare all outputs.
    task automatic step(input string tag);
        int res;
        res = aluRef(int'(x), int'(a_sel ? m_val : a_val), ctl);
        if (reset) begin
            mValid = 0; mOut = 0; mZr = 0; mNg = 0; mJump = 0;
        end else begin
            mValid = in_valid;
            if (in_valid) begin
                mOut  = res[15:0];
                mZr   = (res == 0);
                mNg   = (res >= 32768);
                mJump = jumpRef(res, jmp, c_inst);
            end
        end
        @(posedge clk); #1;
        chk({tag, ".valid"}, 32'(out_valid), 32'(mValid));
        chk({tag, ".out"},   32'(out),       32'(mOut));
        chk({tag, ".zr"},    32'(zr),        32'(mZr));
        chk({tag, ".ng"},    32'(ng),        32'(mNg));
        chk({tag, ".jump"},  32'(jump),      32'(mJump));
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, CTL_ZERO, 3'b000, 0);
        #2;
        chk("rst.valid", 32'(out_valid), 0);
        chk("rst.out", 32'(out), 0);
        chk("rst.flags", {29'd0, zr, ng, jump}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        mValid = 0; mOut = 0; mZr = 0; mNg = 0; mJump = 0;

        drive(1, 16'd5, 16'd3, 16'd0, 0, CTL_XPY, 3'b000, 0);
        step("xpy");
        chk("xpy.const", {15'd0, out_valid, out}, {15'd1, 16'h0008});

        drive(1, 16'd5, 16'd0, 16'd7, 1, CTL_XMY, 3'b100, 1);
        step("xmy_m");
        chk("xmy_m.const", {13'd0, ng, jump, out_valid, out}, {13'd0, 1'b1, 1'b1, 1'b1, 16'hFFFE});

        drive(1, 16'h1234, 16'h4321, 16'd0, 0, CTL_ZERO, 3'b010, 1);
        step("zero_c1");
        chk("zero_c1.const", {14'd0, zr, jump, out}, {14'd0, 1'b1, 1'b1, 16'h0000});
        drive(1, 16'h1234, 16'h4321, 16'd0, 0, CTL_ZERO, 3'b010, 0);
        step("zero_c0");
        chk("zero_c0.jump", 32'(jump), 0);

        drive(1, 16'h8000, 16'h0001, 16'd0, 0, CTL_XMY, 3'b001, 1);
        step("wrap");
        chk("wrap.const", {13'd0, zr, ng, jump, out}, {13'd0, 1'b0, 1'b0, 1'b1, 16'h7FFF});

        drive(1, 16'h00F0, 16'h0F0F, 16'd0, 0, CTL_XANDY, 3'b000, 0);
        step("and");
        chk("and.const", 32'(out), 32'h0000);
        drive(1, 16'h00F0, 16'h0F0F, 16'd0, 0, CTL_XORY, 3'b000, 0);
        step("or");
        chk("or.const", 32'(out), 32'h0FFF);
        drive(1, 16'h00F0, 16'h0F0F, 16'd0, 0, CTL_NOTX, 3'b000, 0);
        step("notx");
        chk("notx.const", 32'(out), 32'hFF0F);

        // Idle cycles: result holds, valid drops.
        drive(0, 16'h1111, 16'h2222, 16'h3333, 0, CTL_ONE, 3'b111, 1);
        step("idle1");
        chk("idle1.const", {15'd0, out_valid, out}, {15'd0, 1'b0, 16'hFF0F});
        step("idle2");

        // Reset between edges while out_valid is high.
        drive(1, 16'd9, 16'd1, 16'd0, 0, CTL_X, 3'b000, 0);
        step("pre_rst");
        #2 reset = 1'b1;
        #1;
        chk("amid_rst.valid", 32'(out_valid), 0);
        chk("amid_rst.out", 32'(out), 0);
        chk("amid_rst.flags", {29'd0, zr, ng, jump}, 0);
        drive(1, 16'd42, 16'd0, 16'd0, 0, CTL_X, 3'b001, 1);
        step("in_rst");
        reset = 1'b0;
        step("post_rst");
        chk("post_rst.const", {15'd0, out_valid, out}, {15'd1, 16'd42});

        for (int i = 0; i < 300; i++) begin
            logic [5:0] c;
            case ($urandom_range(0, 10))
                0: c = CTL_ZERO;  1: c = CTL_ONE;  2: c = CTL_NEG1;
                3: c = CTL_X;     4: c = CTL_NOTX; 5: c = CTL_XPY;
                6: c = CTL_XMY;   7: c = CTL_YMX;  8: c = CTL_XANDY;
                9: c = CTL_XORY;  default: c = 6'($urandom);
            endcase
            drive(($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
                  16'($urandom), 1'($urandom), c, 3'($urandom), 1'($urandom));
            if ($urandom_range(0, 7) == 0) x = ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'hFFFF;
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
